// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - IF-stage program counter with prioritised redirects and a return-address stack
module pc_gen #(
  parameter int                     PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0,
  parameter int                     INC          = 4,
  parameter int                     RAS_DEPTH    = 4
) (
  input  logic                pcg_clk,
  input  logic                pcg_rst,
  input  logic                pcg_i_ce,
  input  logic                pcg_i_stall,
  input  logic                pcg_i_exc,
  input  logic [PC_WIDTH-1:0] pcg_i_exc_pc,
  input  logic                pcg_i_branch,
  input  logic [PC_WIDTH-1:0] pcg_i_branch_pc,
  input  logic                pcg_i_call,
  input  logic [PC_WIDTH-1:0] pcg_i_call_pc,
  input  logic [PC_WIDTH-1:0] pcg_i_ret_addr,
  input  logic                pcg_i_ret,
  output logic [PC_WIDTH-1:0] pcg_o_pc,
  output logic                pcg_o_ce,
  output logic                pcg_o_flush,
  output logic                pcg_o_misalign,
  output logic                pcg_o_ras_empty,
  output logic                pcg_o_ras_full
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PC_WIDTH-1:0] INC_V      = PC_WIDTH'(INC);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INC - 1);
  localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0]    PTR_LAST   = PTR_W'(RAS_DEPTH - 1);

  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]    ras_wp;
  logic [PTR_W-1:0]    wp_next;
  logic [PTR_W-1:0]    wp_prev;
  logic [CNT_W-1:0]    ras_cnt;
  logic                do_push;

  // ras_wp points at the slot the next push writes; the newest entry sits just below it.
  always_comb begin
    wp_next = (ras_wp == PTR_LAST) ? '0 : ras_wp + 1'b1;
    wp_prev = (ras_wp == '0) ? PTR_LAST : ras_wp - 1'b1;
    do_push = pcg_i_ce && pcg_o_ce && !pcg_i_exc && !pcg_i_branch &&
              !pcg_i_stall && pcg_i_call;
  end

  always_ff @(posedge pcg_clk) begin
    if (do_push) begin
      ras_mem[ras_wp] <= pcg_i_ret_addr;
    end
  end

  always_ff @(posedge pcg_clk or negedge pcg_rst) begin
    if (!pcg_rst) begin
      pcg_o_pc    <= RESET_VECTOR;
      pcg_o_ce    <= 1'b0;
      pcg_o_flush <= 1'b0;
      ras_cnt     <= '0;
      ras_wp      <= '0;
    end else begin
      pcg_o_flush <= 1'b0;
      if (!pcg_i_ce) begin
        pcg_o_ce <= 1'b0;
      end else if (!pcg_o_ce) begin
        // Resume: present the held PC once before advancing.
        pcg_o_ce <= 1'b1;
      end else if (pcg_i_exc) begin
        pcg_o_pc    <= pcg_i_exc_pc;
        pcg_o_flush <= 1'b1;
        ras_cnt     <= '0;
        ras_wp      <= '0;
      end else if (pcg_i_branch) begin
        pcg_o_pc    <= pcg_i_branch_pc;
        pcg_o_flush <= 1'b1;
      end else if (pcg_i_stall) begin
        pcg_o_pc <= pcg_o_pc;
      end else if (pcg_i_call) begin
        pcg_o_pc <= pcg_i_call_pc;
        ras_wp   <= wp_next;
        if (ras_cnt != CNT_FULL) begin
          ras_cnt <= ras_cnt + 1'b1;
        end
      end else if (pcg_i_ret && (ras_cnt != '0)) begin
        pcg_o_pc <= ras_mem[wp_prev];
        ras_wp   <= wp_prev;
        ras_cnt  <= ras_cnt - 1'b1;
      end else begin
        pcg_o_pc <= pcg_o_pc + INC_V;
      end
    end
  end

  assign pcg_o_misalign  = pcg_o_ce && ((pcg_o_pc & ALIGN_MASK) != '0);
  assign pcg_o_ras_empty = (ras_cnt == '0);
  assign pcg_o_ras_full  = (ras_cnt == CNT_FULL);

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen with a queue-based reference model
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0, stall = 1'b0, exc = 1'b0, branch = 1'b0, call = 1'b0, ret = 1'b0;
  logic [31:0] exc_pc = '0, branch_pc = '0, call_pc = '0, ret_addr = '0;
  logic [31:0] o_pc;
  logic        o_ce, o_flush, o_misalign, o_empty, o_full;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc = '0;
  logic        m_oce = 1'b0;
  logic        m_flush = 1'b0;
  logic [31:0] m_ras[$];

  pc_gen #(.PC_WIDTH(32), .RESET_VECTOR(32'h0), .INC(4), .RAS_DEPTH(4)) dut (
    .pcg_clk(clk), .pcg_rst(rst_n), .pcg_i_ce(ce), .pcg_i_stall(stall),
    .pcg_i_exc(exc), .pcg_i_exc_pc(exc_pc), .pcg_i_branch(branch),
    .pcg_i_branch_pc(branch_pc), .pcg_i_call(call), .pcg_i_call_pc(call_pc),
    .pcg_i_ret_addr(ret_addr), .pcg_i_ret(ret), .pcg_o_pc(o_pc), .pcg_o_ce(o_ce),
    .pcg_o_flush(o_flush), .pcg_o_misalign(o_misalign),
    .pcg_o_ras_empty(o_empty), .pcg_o_ras_full(o_full)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0; m_oce = 1'b0; m_flush = 1'b0; m_ras.delete();
  endtask

  // Reference behaviour: priority list applied to a plain PC value and a bounded queue.
  task automatic model_step();
    m_flush = 1'b0;
    if (!ce) m_oce = 1'b0;
    else if (!m_oce) m_oce = 1'b1;
    else if (exc) begin m_pc = exc_pc; m_ras.delete(); m_flush = 1'b1; end
    else if (branch) begin m_pc = branch_pc; m_flush = 1'b1; end
    else if (stall) begin end
    else if (call) begin
      m_ras.push_back(ret_addr);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
      m_pc = call_pc;
    end
    else if (ret && m_ras.size() > 0) m_pc = m_ras.pop_back();
    else m_pc = m_pc + 32'd4;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; exc = 0; branch = 0; call = 0; ret = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; ce = 1; idle_inputs();
    tick(); tick();
    checks++; if (o_ce !== 1'b0) begin failures++; $display("FAIL reset_oce got=%b exp=0", o_ce); end
    checks++; if (o_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", o_pc); end
    checks++; if (o_empty !== 1'b1 || o_full !== 1'b0) begin failures++; $display("FAIL reset_ras got=%b%b exp=10", o_empty, o_full); end
    checks++; if (o_flush !== 1'b0 || o_misalign !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", o_flush, o_misalign); end
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL seq_flush edge=%0d got=%b exp=0", i + 1, o_flush); end
      if (i == 0) begin
        checks++; if (o_ce !== 1'b1 || o_pc !== 32'h0) begin failures++; $display("FAIL seq_first got=%b/%h exp=1/0", o_ce, o_pc); end
      end
      if (i == 19) begin
        checks++; if (o_pc !== 32'h4C) begin failures++; $display("FAIL seq_pc20 got=%h exp=4c", o_pc); end
      end
    end
  endtask

  task automatic test_branch_stall();
    branch = 1; branch_pc = 32'h10; tick();
    checks++; if (o_pc !== 32'h10) begin failures++; $display("FAIL br_setup got=%h exp=10", o_pc); end
    stall = 1; branch_pc = 32'h100; tick();
    checks++; if (o_pc !== 32'h100 || o_flush !== 1'b1) begin failures++; $display("FAIL br_over_stall got=%h/%b exp=100/1", o_pc, o_flush); end
    branch = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (o_pc !== 32'h100 || o_flush !== 1'b0 || o_ce !== 1'b1) begin failures++; $display("FAIL stall_hold got=%h/%b/%b exp=100/0/1", o_pc, o_flush, o_ce); end
    end
    stall = 0;
  endtask

  task automatic test_exc_priority();
    call = 1; ret_addr = 32'h10; call_pc = 32'h300; tick();
    ret_addr = 32'h20; call_pc = 32'h400; tick();
    call = 0;
    checks++; if (o_pc !== 32'h400 || o_empty !== 1'b0) begin failures++; $display("FAIL exc_setup got=%h/%b exp=400/0", o_pc, o_empty); end
    exc = 1; exc_pc = 32'h80000180; branch = 1; branch_pc = 32'h200; call = 1; tick();
    idle_inputs();
    checks++; if (o_pc !== 32'h80000180) begin failures++; $display("FAIL exc_pc got=%h exp=80000180", o_pc); end
    checks++; if (o_flush !== 1'b1 || o_empty !== 1'b1) begin failures++; $display("FAIL exc_flush_empty got=%b/%b exp=1/1", o_flush, o_empty); end
  endtask

  task automatic test_ras();
    for (int i = 0; i < 5; i++) begin
      call = 1; ret_addr = 32'((i + 1) * 16); call_pc = 32'h1000 + 32'(i * 256); tick();
      checks++; if (o_full !== (i >= 3)) begin failures++; $display("FAIL ras_full push=%0d got=%b exp=%b", i + 1, o_full, i >= 3); end
    end
    call = 0;
    for (int i = 0; i < 5; i++) begin
      ret = 1; tick();
      if (i < 4) begin
        checks++; if (o_pc !== 32'((5 - i) * 16)) begin failures++; $display("FAIL ras_pop%0d got=%h exp=%h", i + 1, o_pc, (5 - i) * 16); end
      end else begin
        checks++; if (o_pc !== 32'h24 || o_empty !== 1'b1) begin failures++; $display("FAIL ras_underflow got=%h/%b exp=24/1", o_pc, o_empty); end
      end
    end
    ret = 0;
  endtask

  task automatic test_ce_gap();
    branch = 1; branch_pc = 32'h20; tick(); branch = 0;
    ce = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (o_ce !== 1'b0 || o_pc !== 32'h20) begin failures++; $display("FAIL ce_off got=%b/%h exp=0/20", o_ce, o_pc); end
    end
    ce = 1; tick();
    checks++; if (o_ce !== 1'b1 || o_pc !== 32'h20) begin failures++; $display("FAIL ce_resume got=%b/%h exp=1/20", o_ce, o_pc); end
    tick();
    checks++; if (o_pc !== 32'h24) begin failures++; $display("FAIL ce_advance got=%h exp=24", o_pc); end
  endtask

  task automatic test_misalign_wrap();
    branch = 1; branch_pc = 32'h102; tick();
    checks++; if (o_pc !== 32'h102 || o_misalign !== 1'b1) begin failures++; $display("FAIL misalign got=%h/%b exp=102/1", o_pc, o_misalign); end
    branch_pc = 32'hFFFFFFFC; tick(); branch = 0;
    checks++; if (o_pc !== 32'hFFFFFFFC || o_misalign !== 1'b0) begin failures++; $display("FAIL top_addr got=%h/%b exp=fffffffc/0", o_pc, o_misalign); end
    tick();
    checks++; if (o_pc !== 32'h0) begin failures++; $display("FAIL wrap got=%h exp=0", o_pc); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      ce = ($urandom_range(0, 7) != 0);
      exc = ($urandom_range(0, 15) == 0);
      branch = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 5) == 0);
      call = ($urandom_range(0, 3) == 0);
      ret = ($urandom_range(0, 2) == 0);
      exc_pc = $urandom() & 32'hFFFFFFFC;
      branch_pc = ($urandom_range(0, 9) == 0) ? $urandom() : ($urandom() & 32'hFFFFFFFC);
      call_pc = $urandom() & 32'hFFFFFFFC;
      ret_addr = $urandom() & 32'hFFFFFFFC;
      tick();
      checks++; if (o_pc !== m_pc) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", n, o_pc, m_pc); end
      checks++; if (o_ce !== m_oce) begin failures++; $display("FAIL rnd_ce cyc=%0d got=%b exp=%b", n, o_ce, m_oce); end
      checks++; if (o_flush !== m_flush) begin failures++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", n, o_flush, m_flush); end
      checks++; if (o_misalign !== (m_oce && m_pc[1:0] != 2'b00)) begin failures++; $display("FAIL rnd_misalign cyc=%0d got=%b", n, o_misalign); end
      checks++; if (o_empty !== (m_ras.size() == 0) || o_full !== (m_ras.size() == 4)) begin failures++; $display("FAIL rnd_ras cyc=%0d got=%b%b size=%0d", n, o_empty, o_full, m_ras.size()); end
    end
    ce = 1; idle_inputs();
  endtask

  task automatic test_async_reset();
    ce = 1; idle_inputs(); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      call = 1; ret_addr = 32'h500 + 32'(i * 4); call_pc = 32'h600; tick();
    end
    call = 0; branch = 1; branch_pc = 32'h44; tick(); branch = 0;
    checks++; if (o_pc !== 32'h44 || o_full !== 1'b1) begin failures++; $display("FAIL arst_setup got=%h/%b exp=44/1", o_pc, o_full); end
    #3 rst_n = 0;
    model_reset();
    #1;
    checks++; if (o_pc !== 32'h0 || o_ce !== 1'b0) begin failures++; $display("FAIL arst_pc_ce got=%h/%b exp=0/0", o_pc, o_ce); end
    checks++; if (o_empty !== 1'b1 || o_full !== 1'b0) begin failures++; $display("FAIL arst_ras got=%b%b exp=10", o_empty, o_full); end
    tick();
    rst_n = 1;
    tick();
    checks++; if (o_ce !== 1'b1 || o_pc !== 32'h0) begin failures++; $display("FAIL arst_release got=%b/%h exp=1/0", o_ce, o_pc); end
  endtask

  initial begin
    test_reset();
    test_branch_stall();
    test_exc_priority();
    test_ras();
    test_ce_gap();
    test_misalign_wrap();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the MIPS pipeline IF stage, the successor to the basic enable-and-load program counter. It produces the fetch address and fetch-valid strobe. Redirect sources are prioritised: exception, resolved branch/jump from EX, and predicted call/return from ID. A small return-address stack (RAS) predicts returns, and the block emits a one-cycle flush pulse on hard redirects.

## Interface
- PC_WIDTH, 32, width of all address ports
- RESET_VECTOR, 0, PC value after reset; must be INC-aligned
- INC, 4, sequential increment; power of two
- RAS_DEPTH, 4, return-address stack entries (≥1)

- pcg_clk  in  1  clock, rising edge
- pcg_rst  in  1  reset, asynchronous, active-low
- pcg_i_ce  in  1  fetch enable
- pcg_i_stall  in  1  hold current PC (pipeline stall)
- pcg_i_exc  in  1  exception redirect request
- pcg_i_exc_pc  in  PC_WIDTH  exception handler address
- pcg_i_branch  in  1  resolved branch/jump redirect from EX (mispredict correction)
- pcg_i_branch_pc  in  PC_WIDTH  branch target
- pcg_i_call  in  1  ID decoded a call: push return address, redirect to call target
- pcg_i_call_pc  in  PC_WIDTH  call target
- pcg_i_ret_addr  in  PC_WIDTH  return address to push on call
- pcg_i_ret  in  1  ID decoded a return: pop RAS and redirect to the popped address
- pcg_o_pc  out  PC_WIDTH  fetch address
- pcg_o_ce  out  1  fetch address valid
- pcg_o_flush  out  1  one-cycle pulse: younger instructions must be squashed
- pcg_o_misalign  out  1  pcg_o_pc low log2(INC) bits nonzero, gated by pcg_o_ce
- pcg_o_ras_empty  out  1  RAS count == 0
- pcg_o_ras_full  out  1  RAS count == RAS_DEPTH

## Operation
- Reset (async, any time, including mid-operation): pc=RESET_VECTOR, o_ce=0, o_flush=0, RAS count=0 (empty=1, full=0), misalign=0.
- Each rising edge, evaluated in this order:
  - ce=0: o_ce←0; PC and RAS hold; every other input is ignored; o_flush←0.
  - ce=1, o_ce=0 (start or resume): o_ce←1; PC holds, so the held or reset PC is presented once before advancing; other inputs are ignored.
  - ce=1, o_ce=1: first matching source wins.
    1. exc: PC←exc_pc; RAS emptied; o_flush←1.
    2. branch: PC←branch_pc; RAS untouched; o_flush←1. Call/ret in the same cycle are dropped, because the ID instruction is being squashed.
    3. stall: PC and RAS hold; call/ret are ignored (the instruction is re-presented later).
    4. call: push ret_addr; PC←call_pc. If both call and ret are asserted, call wins and ret is ignored.
    5. ret with RAS non-empty: pop; PC←popped value.
    6. ret with RAS empty: no pop; PC←PC+INC (EX corrects later).
    7. Otherwise: PC←PC+INC.
  - o_flush←0 in every case not listed above.
- RAS is circular.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop returns the most recent entry and decrements count.
  - Count width is clog2(RAS_DEPTH+1).
- Arithmetic: PC+INC is modulo 2^PC_WIDTH, so the maximum aligned address wraps to 0.
- Misaligned targets are loaded unchanged and flagged; the block does no correction.

## Timing
- All outputs are registered except misalign, ras_empty and ras_full, which are combinational from state.
- Redirect latency is one edge: the target appears on o_pc in the cycle after the request is sampled. o_flush is high in that same cycle only.
- o_ce rises one edge after ce is sampled high and falls one edge after ce is sampled low.
- Stall asserted for N cycles holds o_pc for N cycles; o_ce stays 1.
- RAS push/pop takes effect at the same edge as the redirect; empty/full update in the following cycle.
- Reset assertion clears outputs without a clock edge. Deassertion is synchronised by the user; the first edge after release obeys the rules above.

## Test plan
Parameters for all scenarios: PC_WIDTH=32, RESET_VECTOR=0, INC=4, RAS_DEPTH=4.
- Reset low for 2 edges, then ce=1 held for 20 edges → o_ce=0 during reset; after edge 1 o_ce=1, pc=0x0; after edge 20 pc=0x4C; flush never set.
- At pc=0x10, stall=1 and branch=1 (branch_pc=0x100) → next cycle pc=0x100, flush=1 for exactly one cycle; with stall still high, pc holds 0x100.
- exc=1 (exc_pc=0x80000180), branch=1 (0x200), call=1, with 2 RAS entries present → pc=0x80000180, flush=1, ras_empty=1.
- Five calls pushing 0x10, 0x20, 0x30, 0x40, 0x50 → ras_full after the 4th. Then five rets → pc=0x50, 0x40, 0x30, 0x20; the 5th ret finds RAS empty, so pc=previous+4 and ras_empty=1.
- At pc=0x20, ce=0 for 3 edges → o_ce=0, pc=0x20. Then ce=1 → after edge 1 o_ce=1, pc=0x20; after edge 2 pc=0x24.
- branch_pc=0x102 → pc=0x102, misalign=1. Then branch_pc=0xFFFFFFFC → pc=0xFFFFFFFC, misalign=0; next edge pc=0x0.
- Async reset mid-stream with pc=0x44, RAS full → pc=0, o_ce=0, ras_empty=1 immediately, without a clock edge.
